alu_share_ctrl: RTL and testbench

Sequencing and arbitration controller that shares one 4-bit combinational ALU (ripple-carry add/subtract, AND, OR, XOR, 4:1 output mux, overflow flag) between two requesters. Each accepted request registers its operands and operation onto the ALU ports and holds them for a programmable settle window. It then captures the ALU result and overflow into a response register and returns them with a requester ID over a valid/ready response channel. The block sits between the two requesting agents and the ALU instance.

---
 rtl/alu_share_ctrl_if.sv | 50 +++++
 rtl/alu_share_ctrl.sv | 112 +++++++++++
 tb/tb_alu_share_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_ctrl_if.sv
// Bundle of the two requester channels, the response channel and the ALU port
// of alu_share_ctrl. The slave modport is the controller side.
interface alu_share_ctrl_if;
  logic       r0_req;
  logic [2:0] r0_op;
  logic [3:0] r0_a;
  logic [3:0] r0_b;
  logic       r0_gnt;

  logic       r1_req;
  logic [2:0] r1_op;
  logic [3:0] r1_a;
  logic [3:0] r1_b;
  logic       r1_gnt;

  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [3:0] rsp_result;
  logic       rsp_ov;

  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_sel;
  logic       alu_binv;
  logic [3:0] alu_out;
  logic       alu_ov;

  modport master (
    output r0_req, r0_op, r0_a, r0_b,
    input  r0_gnt,
    output r1_req, r1_op, r1_a, r1_b,
    input  r1_gnt,
    input  rsp_valid, rsp_id, rsp_result, rsp_ov,
    output rsp_ready,
    input  alu_a, alu_b, alu_sel, alu_binv,
    output alu_out, alu_ov
  );

  modport slave (
    input  r0_req, r0_op, r0_a, r0_b,
    output r0_gnt,
    input  r1_req, r1_op, r1_a, r1_b,
    output r1_gnt,
    output rsp_valid, rsp_id, rsp_result, rsp_ov,
    input  rsp_ready,
    output alu_a, alu_b, alu_sel, alu_binv,
    input  alu_out, alu_ov
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Shares one combinational 4-bit ALU between two requesters: round-robin grant,
// registered ALU operands held for HOLD_CYCLES, then a valid/ready response.
module alu_share_ctrl #(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input logic             clk,
  input logic             rst_n,
  alu_share_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t     state, state_nxt;
  logic       ptr;
  logic       owner;
  logic [3:0] cnt;
  logic       gnt0, gnt1;

  logic [3:0] alu_a_q, alu_b_q;
  logic [1:0] alu_sel_q;
  logic       alu_binv_q;
  logic       rsp_valid_q, rsp_id_q, rsp_ov_q;
  logic [3:0] rsp_result_q;

  logic [2:0] win_op;
  logic [3:0] win_a, win_b;

  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    case (state)
      IDLE: begin
        // Contention goes to r0 when ptr=0, to r1 when ptr=1.
        if (bus.r0_req && (!bus.r1_req || !ptr)) gnt0 = 1'b1;
        else if (bus.r1_req)                     gnt1 = 1'b1;
        if (gnt0 || gnt1) state_nxt = EXEC;
      end
      EXEC:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign win_op = gnt1 ? bus.r1_op : bus.r0_op;
  assign win_a  = gnt1 ? bus.r1_a  : bus.r0_a;
  assign win_b  = gnt1 ? bus.r1_b  : bus.r0_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= 1'b0;
      owner        <= 1'b0;
      cnt          <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      alu_binv_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_ov_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            alu_a_q    <= win_a;
            alu_b_q    <= win_b;
            alu_sel_q  <= win_op[1:0];
            alu_binv_q <= win_op[2] & (win_op[1:0] == 2'b00);
            owner      <= gnt1;
            ptr        <= ~gnt1;
            cnt        <= 4'(HOLD_CYCLES - 1);
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_result_q <= bus.alu_out;
            rsp_ov_q     <= bus.alu_ov & (alu_sel_q == 2'b00);
            rsp_id_q     <= owner;
            rsp_valid_q  <= 1'b1;
          end
        end
        RESP:    if (bus.rsp_ready) rsp_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Grants are combinational, so they are gated with reset explicitly.
  assign bus.r0_gnt     = gnt0 & rst_n;
  assign bus.r1_gnt     = gnt1 & rst_n;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_sel    = alu_sel_q;
  assign bus.alu_binv   = alu_binv_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_ov     = rsp_ov_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: one instance with HOLD_CYCLES=1 and one
// with HOLD_CYCLES=3, each attached to a behavioural 4-bit ALU.
`timescale 1ns/1ps
module tb_alu_share_ctrl;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_share_ctrl_if if1 ();
  alu_share_ctrl_if if3 ();

  alu_share_ctrl #(.HOLD_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  alu_share_ctrl #(.HOLD_CYCLES(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  // Overflow always comes from the adder, so the controller must mask it for logic ops.
  function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] sel, input logic binv);
    logic [3:0] bb, s;
    logic       ov;
    bb = binv ? ~b : b;
    s  = a + bb + {3'b000, binv};
    ov = (a[3] == bb[3]) && (s[3] != a[3]);
    case (sel)
      2'b00:   alu_f = {ov, s};
      2'b01:   alu_f = {ov, a & bb};
      2'b10:   alu_f = {ov, a | bb};
      default: alu_f = {ov, a ^ bb};
    endcase
  endfunction

  always_comb {if1.alu_ov, if1.alu_out} = alu_f(if1.alu_a, if1.alu_b, if1.alu_sel, if1.alu_binv);
  always_comb {if3.alu_ov, if3.alu_out} = alu_f(if3.alu_a, if3.alu_b, if3.alu_sel, if3.alu_binv);

  typedef struct packed {
    logic       id;
    logic [3:0] res;
    logic       ov;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitors: pop one expected response per handshake.
  always @(negedge clk) begin
    exp_t e;
    if (if1.rsp_valid === 1'b1 && if1.rsp_ready === 1'b1) begin
      if (q1.size() == 0) begin
        fail_now("dut1 unexpected response (none expected)");
      end else begin
        e = q1.pop_front();
        check("dut1 rsp_id", if1.rsp_id, e.id);
        check("dut1 rsp_result", if1.rsp_result, e.res);
        check("dut1 rsp_ov", if1.rsp_ov, e.ov);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (if3.rsp_valid === 1'b1 && if3.rsp_ready === 1'b1) begin
      if (q3.size() == 0) begin
        fail_now("dut3 unexpected response (none expected)");
      end else begin
        e = q3.pop_front();
        check("dut3 rsp_id", if3.rsp_id, e.id);
        check("dut3 rsp_result", if3.rsp_result, e.res);
        check("dut3 rsp_ov", if3.rsp_ov, e.ov);
      end
    end
  end

  task automatic drive1(input int rq, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    if (rq == 0) begin
      if1.r0_req = 1'b1; if1.r0_op = op; if1.r0_a = a; if1.r0_b = b;
    end else begin
      if1.r1_req = 1'b1; if1.r1_op = op; if1.r1_a = a; if1.r1_b = b;
    end
  endtask

  task automatic wait_gnt1(input int rq, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((rq == 0) ? if1.r0_gnt : if1.r1_gnt) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain1(input string name);
    for (int i = 0; i < 40 && q1.size() != 0; i++) @(negedge clk);
    if (q1.size() != 0) fail_now(name);
    @(posedge clk); #1;
  endtask

  // Single request on dut1: grant, registered operands, latency, response.
  task automatic run_op1(input string name, input int rq, input logic [2:0] op,
                         input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] exp_res, input logic exp_ov, input logic exp_binv);
    bit ok;
    int lat;
    q1.push_back(exp_t'{id: rq[0], res: exp_res, ov: exp_ov});
    drive1(rq, op, a, b);
    wait_gnt1(rq, ok);
    if (!ok) begin
      fail_now({name, " grant"});
      if1.r0_req = 1'b0; if1.r1_req = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if1.r0_req = 1'b0; if1.r1_req = 1'b0;
    check({name, " alu_a"}, if1.alu_a, a);
    check({name, " alu_b"}, if1.alu_b, b);
    check({name, " alu_binv"}, if1.alu_binv, exp_binv);
    lat = 0;
    while (if1.rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, lat, 1);
    drain1({name, " response"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int n, last, cyc, lat;

    rst_n = 1'b0;
    if1.r0_req = 1'b0; if1.r0_op = '0; if1.r0_a = '0; if1.r0_b = '0;
    if1.r1_req = 1'b0; if1.r1_op = '0; if1.r1_a = '0; if1.r1_b = '0;
    if1.rsp_ready = 1'b1;
    if3.r0_req = 1'b0; if3.r0_op = '0; if3.r0_a = '0; if3.r0_b = '0;
    if3.r1_req = 1'b0; if3.r1_op = '0; if3.r1_a = '0; if3.r1_b = '0;
    if3.rsp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("reset dut1 rsp_valid", if1.rsp_valid, 1'b0);
    check("reset dut1 rsp_result", if1.rsp_result, 4'b0000);
    check("reset dut1 alu_a", if1.alu_a, 4'b0000);
    check("reset dut1 alu_sel", if1.alu_sel, 2'b00);
    check("reset dut3 rsp_valid", if3.rsp_valid, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Both requesters held: grants alternate 0,1,0,1 every HOLD+2 cycles.
    q1.push_back(exp_t'{id: 1'b0, res: 4'b1000, ov: 1'b1});
    q1.push_back(exp_t'{id: 1'b1, res: 4'b0101, ov: 1'b0});
    q1.push_back(exp_t'{id: 1'b0, res: 4'b1000, ov: 1'b1});
    q1.push_back(exp_t'{id: 1'b1, res: 4'b0101, ov: 1'b0});
    drive1(0, 3'b000, 4'b0111, 4'b0001);
    drive1(1, 3'b011, 4'b0110, 4'b0011);
    n = 0; last = 0; cyc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cyc++;
      check("arb no gnt while rsp_valid", (if1.r0_gnt | if1.r1_gnt) & if1.rsp_valid, 1'b0);
      if (if1.r0_gnt | if1.r1_gnt) begin
        check("arb single gnt", if1.r0_gnt & if1.r1_gnt, 1'b0);
        if (n > 0) check("arb grant spacing", cyc - last, 3);
        last = cyc;
        n++;
        if (n == 4) begin
          @(posedge clk); #1;
          if1.r0_req = 1'b0; if1.r1_req = 1'b0;
          break;
        end
      end
    end
    if (n != 4) begin
      fail_now("arb four grants");
      if1.r0_req = 1'b0; if1.r1_req = 1'b0;
    end
    drain1("arb responses");

    run_op1("add ovf", 0, 3'b000, 4'b0101, 4'b0011, 4'b1000, 1'b1, 1'b0);
    run_op1("sub",     1, 3'b100, 4'b0011, 4'b0101, 4'b1110, 1'b0, 1'b1);
    run_op1("and binv", 0, 3'b101, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0);

    // Backpressure on the HOLD_CYCLES=3 instance with r1 waiting.
    if3.rsp_ready = 1'b0;
    q3.push_back(exp_t'{id: 1'b0, res: 4'b0011, ov: 1'b0});
    if3.r0_req = 1'b1; if3.r0_op = 3'b010; if3.r0_a = 4'b0010; if3.r0_b = 4'b0011;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if3.r0_gnt) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("bp r0 grant");
    @(posedge clk); #1;
    if3.r0_req = 1'b0;
    q3.push_back(exp_t'{id: 1'b1, res: 4'b0111, ov: 1'b1});
    if3.r1_req = 1'b1; if3.r1_op = 3'b100; if3.r1_a = 4'b1000; if3.r1_b = 4'b0001;
    lat = 0;
    while (if3.rsp_valid !== 1'b1 && lat < 20) begin
      check("bp r1_gnt low in EXEC", if3.r1_gnt, 1'b0);
      @(posedge clk); #1;
      lat++;
    end
    check("bp first latency", lat, 3);
    for (int i = 0; i < 5; i++) begin
      check("bp rsp_valid held", if3.rsp_valid, 1'b1);
      check("bp rsp_id held", if3.rsp_id, 1'b0);
      check("bp rsp_result held", if3.rsp_result, 4'b0011);
      check("bp rsp_ov held", if3.rsp_ov, 1'b0);
      check("bp r1_gnt low in RESP", if3.r1_gnt, 1'b0);
      @(posedge clk); #1;
    end
    if3.rsp_ready = 1'b1;
    check("bp r1_gnt low at handshake", if3.r1_gnt, 1'b0);
    @(posedge clk); #1;
    check("bp r1 granted first IDLE", if3.r1_gnt, 1'b1);
    @(posedge clk); #1;
    if3.r1_req = 1'b0;
    lat = 0;
    while (if3.rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp second latency", lat, 3);
    for (int i = 0; i < 40 && q3.size() != 0; i++) @(negedge clk);
    if (q3.size() != 0) fail_now("bp responses");
    @(posedge clk); #1;

    // Reset during EXEC just after r0 wins (ptr=1); reset must bring ptr back to 0.
    drive1(0, 3'b000, 4'b0001, 4'b0001);
    wait_gnt1(0, ok);
    if (!ok) fail_now("rst pre-grant");
    @(posedge clk); #1;
    drive1(0, 3'b011, 4'b1001, 4'b0101);
    drive1(1, 3'b000, 4'b0001, 4'b0001);
    rst_n = 1'b0;
    #1;
    check("rst rsp_valid", if1.rsp_valid, 1'b0);
    check("rst rsp_id", if1.rsp_id, 1'b0);
    check("rst rsp_result", if1.rsp_result, 4'b0000);
    check("rst rsp_ov", if1.rsp_ov, 1'b0);
    check("rst alu_a", if1.alu_a, 4'b0000);
    check("rst alu_b", if1.alu_b, 4'b0000);
    check("rst alu_sel", if1.alu_sel, 2'b00);
    check("rst alu_binv", if1.alu_binv, 1'b0);
    check("rst gnts low", {if1.r0_gnt, if1.r1_gnt}, 2'b00);
    @(posedge clk); #1;
    check("rst gnts low held", {if1.r0_gnt, if1.r1_gnt}, 2'b00);
    q1.push_back(exp_t'{id: 1'b0, res: 4'b1100, ov: 1'b0});
    rst_n = 1'b1;
    @(negedge clk);
    check("rst r0 wins after reset", {if1.r0_gnt, if1.r1_gnt}, 2'b10);
    @(posedge clk); #1;
    if1.r0_req = 1'b0; if1.r1_req = 1'b0;
    drain1("rst post-reset response");
    repeat (10) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
